mul_div_unit: RTL and testbench

- Iterative multiply/divide unit consuming the two register-file read operands (rs, rt) in the execute stage.
- Produces the architectural HI/LO pair for MULT/MULTU/DIV/DIVU and supports MTHI/MTLO writes.
- Exposes busy so the pipeline controller stalls MFHI/MFLO and further mul/div ops until the result retires.
- Multi-cycle radix-2 shift-add / restoring-subtract datapath, one bit per cycle.

---
 rtl/mul_div_unit_if.sv | 17 +
 rtl/mul_div_unit.sv | 136 +++++++++++++
 tb/tb_mul_div_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Execute-stage bus between the pipeline and the iterative mul/div unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic             flush;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output start, op, flush, operand_a, operand_b,
                  input  hi, lo, busy, done);
  modport slave  (input  start, op, flush, operand_a, operand_b,
                  output hi, lo, busy, done);
endinterface

// File: rtl/mul_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO.
// Define MUL_DIV_FAST_MULT_EN to compute multiplies with a one-shot product.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo, hi_q, lo_q;
  logic             is_mul, neg_lo, neg_hi, done_q;
  logic             busy, fix_write, fast_stage;

  // Decode of the request presented in IDLE
  logic             accept, req_md, req_mul, sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign accept  = (state == IDLE) && bus.start && !bus.flush;
  assign req_md  = !bus.op[2];
  assign req_mul = (bus.op[2:1] == 2'b00);
  assign sa      = !bus.op[0] && bus.operand_a[WIDTH-1];
  assign sb      = !bus.op[0] && bus.operand_b[WIDTH-1];
  assign a_mag   = sa ? -bus.operand_a : bus.operand_a;
  assign b_mag   = sb ? -bus.operand_b : bus.operand_b;

  // One iteration: acc_hi is the running high product / partial remainder,
  // acc_lo is the multiplier being shifted out / the quotient being shifted in.
  logic [WIDTH:0] add_sum, shifted, diff;
  assign add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
  assign shifted = {acc_hi, acc_lo[WIDTH-1]};
  assign diff    = shifted - {1'b0, mcand};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
  assign prod   = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign res_hi = is_mul ? prod[2*WIDTH-1:WIDTH] : (neg_hi ? -acc_hi : acc_hi);
  assign res_lo = is_mul ? prod[WIDTH-1:0]       : (neg_lo ? -acc_lo : acc_lo);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && req_md) begin
`ifdef MUL_DIV_FAST_MULT_EN
        state_nxt = req_mul ? FIX : CALC;
`else
        state_nxt = CALC;
`endif
      end
      CALC: if (bus.flush)                     state_nxt = IDLE;
            else if (cnt == CW'(WIDTH - 1))    state_nxt = FIX;
      FIX:  state_nxt = (fast_stage) ? FIX : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
`ifdef MUL_DIV_FAST_MULT_EN
    // Fast multiply spends its first FIX cycle registering the raw product
    fast_stage = (state == FIX) && !bus.flush && is_mul && (cnt == '0);
`else
    fast_stage = 1'b0;
`endif
    fix_write  = (state == FIX) && !bus.flush && !fast_stage;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_mul <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fix_write;
      if (accept) begin
        if (bus.op == OP_MTHI) hi_q <= bus.operand_a;
        if (bus.op == OP_MTLO) lo_q <= bus.operand_a;
        if (req_md) begin
          cnt    <= '0;
          mcand  <= req_mul ? a_mag : b_mag;
          acc_hi <= '0;
          acc_lo <= req_mul ? b_mag : a_mag;
          is_mul <= req_mul;
          // Divide by zero keeps the all-ones quotient unsigned; the remainder
          // path rebuilds operand_a from its magnitude and sign.
          neg_lo <= (sa ^ sb) && (req_mul || (bus.operand_b != '0));
          neg_hi <= sa;
        end
      end
      if (state == CALC && !bus.flush) begin
        cnt <= cnt + 1'b1;
        if (is_mul)        {acc_hi, acc_lo} <= {add_sum, acc_lo[WIDTH-1:1]};
        else if (!diff[WIDTH]) begin
          acc_hi <= diff[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi <= shifted[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end
      end
`ifdef MUL_DIV_FAST_MULT_EN
      if (fast_stage) begin
        {acc_hi, acc_lo} <= {{WIDTH{1'b0}}, mcand} * {{WIDTH{1'b0}}, acc_lo};
        cnt              <= CW'(1);
      end
`endif
      if (fix_write) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy;
  assign bus.done = done_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO/latency queued at launch.
module tb_mul_div_unit;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = {1'b1, {W-1{1'b0}}};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(W)) bus();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;
  exp_t sb[$];

  function automatic logic [2*W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0]        r;
    logic signed [2*W-1:0] sp;
    logic signed [W-1:0]   q, m;
    r = '0;
    case (op)
      3'd0: begin sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b}); r = sp; end
      3'd1: r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      3'd2: begin
        if (b == '0)                    r = {a, {W{1'b1}}};
        else if (a == MIN && b == '1)   r = {{W{1'b0}}, MIN};
        else begin
          q = $signed(a) / $signed(b);
          m = $signed(a) % $signed(b);
          r = {m, q};
        end
      end
      3'd3: r = (b == '0) ? {a, {W{1'b1}}} : {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [2:0] op);
`ifdef MUL_DIV_FAST_MULT_EN
    if (op[2:1] == 2'b00) return 2;
`endif
    return W + 1;
  endfunction

  task automatic push_exp(input logic [W-1:0] h, input logic [W-1:0] l, input int lat);
    exp_t e;
    e.hi = h; e.lo = l; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic push_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    r = model(op, a, b);
    push_exp(r[2*W-1:W], r[W-1:0], lat_of(op));
  endtask

  // Returns at the negedge right after the accepting edge
  task automatic launch(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_result(input string name, input int n0);
    int n;
    bit stable;
    logic [W-1:0] h0, l0;
    exp_t e;
    n = n0; stable = 1'b1; h0 = bus.hi; l0 = bus.lo;
    while (bus.done !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
      if (bus.done !== 1'b1 && (bus.hi !== h0 || bus.lo !== l0)) stable = 1'b0;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles", name, n);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (!stable) begin errors++; $display("FAIL %s: hi/lo changed before done", name); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL %s: done with empty scoreboard", name); return; end
    e = sb.pop_front();
    checks++;
    if (bus.hi !== e.hi) begin errors++; $display("FAIL %s hi: got %h want %h", name, bus.hi, e.hi); end
    checks++;
    if (bus.lo !== e.lo) begin errors++; $display("FAIL %s lo: got %h want %h", name, bus.lo, e.lo); end
    checks++;
    if (n !== e.lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, n, e.lat); end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL %s pulse: done=%b busy=%b want 0 0", name, bus.done, bus.busy);
    end
  endtask

  task automatic check_hl(input string name, input logic [W-1:0] h, input logic [W-1:0] l);
    checks++;
    if (bus.hi !== h || bus.lo !== l) begin
      errors++; $display("FAIL %s: hi=%h lo=%h want %h %h", name, bus.hi, bus.lo, h, l);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.hi !== '0 || bus.lo !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b want 0", bus.hi, bus.lo, bus.busy, bus.done);
    end
    reset = 1'b1;
  endtask

  task automatic test_mthi_mtlo;
    launch(3'b100, 32'h1111_2222, 32'h0);
    check_hl("mthi", 32'h1111_2222, 32'h0);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mthi_flags: done=%b busy=%b", bus.done, bus.busy); end
    launch(3'b101, 32'h3333_4444, 32'h0);
    check_hl("mtlo", 32'h1111_2222, 32'h3333_4444);
  endtask

  task automatic test_mult;
    launch(3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFA, lat_of(3'b000));
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b want 1", bus.busy); end
    wait_result("mult", 0);
    launch(3'b001, 32'hFFFF_FFFE, 32'h0000_0003);
    push_exp(32'h0000_0002, 32'hFFFF_FFFA, lat_of(3'b001));
    wait_result("multu", 0);
  endtask

  task automatic test_div;
    launch(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, W + 1);
    wait_result("div_neg", 0);
    launch(3'b011, 32'd100, 32'd7);
    push_exp(32'd2, 32'd14, W + 1);
    wait_result("divu", 0);
    launch(3'b010, MIN, 32'hFFFF_FFFF);
    push_exp(32'h0, MIN, W + 1);
    wait_result("div_min", 0);
    launch(3'b010, 32'd1000, 32'hFFFF_FFFD);
    push_model(3'b010, 32'd1000, 32'hFFFF_FFFD);
    wait_result("div_negdiv", 0);
  endtask

  task automatic test_div_zero;
    launch(3'b011, 32'h0000_1234, 32'h0);
    push_exp(32'h0000_1234, 32'hFFFF_FFFF, W + 1);
    wait_result("divu_zero", 0);
    launch(3'b010, 32'hFFFF_FFFB, 32'h0);
    push_exp(32'hFFFF_FFFB, 32'hFFFF_FFFF, W + 1);
    wait_result("div_zero", 0);
  endtask

  task automatic test_busy_ignore;
    int n;
    launch(3'b000, 32'h0000_1234, 32'hFFFF_FFF0);
    push_model(3'b000, 32'h0000_1234, 32'hFFFF_FFF0);
    n = 0;
    repeat (4) begin @(negedge clk); n++; end
    bus.start = 1'b1; bus.op = 3'b010; bus.operand_a = 32'd50; bus.operand_b = 32'd5;
    @(negedge clk); n++;
    bus.op = 3'b101; bus.operand_a = 32'h0000_CAFE;
    @(negedge clk); n++;
    bus.start = 1'b0;
    wait_result("busy_mult", n);
  endtask

  task automatic test_flush;
    bit seen;
    launch(3'b100, 32'h0000_A5A5, 32'h0);
    launch(3'b101, 32'h0000_5A5A, 32'h0);
    launch(3'b010, 32'd12345, 32'd17);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
    check_hl("flush_hold", 32'h0000_A5A5, 32'h0000_5A5A);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.done === 1'b1) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL flush_done: got done pulse want none"); end
    @(negedge clk);
    bus.flush = 1'b1; bus.start = 1'b1; bus.op = 3'b100; bus.operand_a = 32'hDEAD_0000;
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    check_hl("flush_idle_mthi", 32'h0000_A5A5, 32'h0000_5A5A);
  endtask

  task automatic test_undefined_op;
    launch(3'b110, 32'hBEEF_0000, 32'h1);
    @(negedge clk);
    check_hl("undef_op", 32'h0000_A5A5, 32'h0000_5A5A);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL undef_flags: busy=%b done=%b", bus.busy, bus.done); end
  endtask

  task automatic test_reset_mid;
    launch(3'b000, 32'h0000_7777, 32'h0000_0009);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_hl("reset_mid", 32'h0, 32'h0);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_mid_flags: busy=%b done=%b", bus.busy, bus.done); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_resume: busy=%b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 3) ? 32'h0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      launch(op, a, b);
      push_model(op, a, b);
      wait_result($sformatf("b2b_%0d_op%0d", i, op), 0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'b0; bus.flush = 1'b0;
    bus.operand_a = '0; bus.operand_b = '0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_flush();
    test_undefined_op();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
